// File: rtl/menu_param_ctrl.sv
// menu_param_ctrl: front-panel button conditioning plus the navigate/edit
// state machine for the on-screen menu. It holds the four menu parameters
// as BCD digit fields. The values shown to the overlay change only at frame
// boundaries, and the status and cursor outputs come straight from registers.
module menu_param_ctrl #(
   parameter int         bit_data_in = 20,
   parameter int         DEB_LIMIT   = 16,
   parameter int         DEB_W       = 5,
   parameter logic [7:0] MODE_MAX    = 8'h15,
   parameter int         RPT_DELAY   = 30,
   parameter int         RPT_RATE    = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   newframe,
   input  logic                   btn_up,
   input  logic                   btn_down,
   input  logic                   btn_sel,
   input  logic                   btn_menu,
   output logic                   menu_on,
   output logic                   edit_active,
   output logic [1:0]             cursor,
   output logic [bit_data_in-1:0] out_mode,
   output logic [bit_data_in-1:0] out_Type_AGC,
   output logic [bit_data_in-1:0] out_Set_LVL1,
   output logic [bit_data_in-1:0] out_Set_LVL2
);

   localparam int RD_W = $clog2(RPT_DELAY + 1);
   localparam int RR_W = $clog2(RPT_RATE + 1);

   // Button slot indices inside the packed conditioning vectors
   localparam int B_MENU = 0;
   localparam int B_SEL  = 1;
   localparam int B_UP   = 2;
   localparam int B_DOWN = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_NAV  = 2'd1,
      ST_EDIT = 2'd2
   } state_t;

   // Upper bound of each parameter, indexed by cursor position
   function automatic logic [19:0] param_max(input logic [1:0] idx);
      logic [19:0] r;
      case (idx)
         2'd0:    r = {12'h000, MODE_MAX};
         2'd1:    r = 20'h00003;
         2'd2:    r = 20'h99999;
         2'd3:    r = 20'h09999;
         default: r = 20'h00000;
      endcase
      return r;
   endfunction

   // Digit-serial BCD increment; the maximum value (or anything above it) wraps to zero
   function automatic logic [19:0] bcd_inc(input logic [19:0] v, input logic [19:0] vmax);
      logic [19:0] r;
      logic        carry;
      logic [3:0]  d;
      r     = v;
      carry = 1'b1;
      if (v >= vmax) begin
         r = 20'h00000;
      end else begin
         for (int i = 0; i < 5; i++) begin
            d = v[4*i +: 4];
            if (carry) begin
               if (d >= 4'd9) begin
                  r[4*i +: 4] = 4'd0;
               end else begin
                  r[4*i +: 4] = d + 4'd1;
                  carry       = 1'b0;
               end
            end else begin
               r[4*i +: 4] = d;
            end
         end
      end
      return r;
   endfunction

   // Digit-serial BCD decrement; zero (or an out-of-range value) wraps to the maximum
   function automatic logic [19:0] bcd_dec(input logic [19:0] v, input logic [19:0] vmax);
      logic [19:0] r;
      logic        borrow;
      logic [3:0]  d;
      r      = v;
      borrow = 1'b1;
      if ((v == 20'h00000) || (v > vmax)) begin
         r = vmax;
      end else begin
         for (int i = 0; i < 5; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
               if (d == 4'd0) begin
                  r[4*i +: 4] = 4'd9;
               end else begin
                  r[4*i +: 4] = d - 4'd1;
                  borrow      = 1'b0;
               end
            end else begin
               r[4*i +: 4] = d;
            end
         end
      end
      return r;
   endfunction

   logic [3:0]       raw_s;
   logic [3:0]       sync1_r;
   logic [3:0]       sync2_r;
   logic [3:0]       deb_r;
   logic [3:0]       press_r;
   logic [DEB_W-1:0] deb_cnt_r [4];

   logic             ev_menu_s;
   logic             ev_sel_s;
   logic             ev_up_s;
   logic             ev_dn_s;

   logic             held_up_s;
   logic             held_dn_s;
   logic             rpt_run_s;
   logic             rpt_fire_s;
   logic [RD_W-1:0]  rpt_delay_r;
   logic [RD_W-1:0]  rpt_delay_nx_s;
   logic [RR_W-1:0]  rpt_rate_r;
   logic [RR_W-1:0]  rpt_rate_nx_s;
   logic             do_inc_s;
   logic             do_dec_s;

   state_t           state_r;
   logic             menu_on_r;
   logic             edit_active_r;
   logic [1:0]       cursor_r;
   logic [19:0]      pend_r [4];

   logic [bit_data_in-1:0] out_mode_r;
   logic [bit_data_in-1:0] out_agc_r;
   logic [bit_data_in-1:0] out_lvl1_r;
   logic [bit_data_in-1:0] out_lvl2_r;

   assign raw_s = {btn_down, btn_up, btn_sel, btn_menu};

   // Two-flop synchronizer, debounce counter and rising-edge press pulse per button
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 4'b0000;
         sync2_r <= 4'b0000;
         deb_r   <= 4'b0000;
         press_r <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            deb_cnt_r[i] <= '0;
         end
      end else begin
         sync1_r <= raw_s;
         sync2_r <= sync1_r;
         for (int i = 0; i < 4; i++) begin
            if (sync2_r[i] != deb_r[i]) begin
               if (deb_cnt_r[i] == DEB_W'(DEB_LIMIT - 1)) begin
                  deb_r[i]     <= sync2_r[i];
                  deb_cnt_r[i] <= '0;
                  press_r[i]   <= sync2_r[i];
               end else begin
                  deb_cnt_r[i] <= deb_cnt_r[i] + DEB_W'(1);
                  press_r[i]   <= 1'b0;
               end
            end else begin
               deb_cnt_r[i] <= '0;
               press_r[i]   <= 1'b0;
            end
         end
      end
   end

   // Press priority menu > sel > up > down; losers in the same cycle are dropped
   always_comb begin
      ev_menu_s = press_r[B_MENU];
      ev_sel_s  = press_r[B_SEL]  & ~press_r[B_MENU];
      ev_up_s   = press_r[B_UP]   & ~press_r[B_SEL] & ~press_r[B_MENU];
      ev_dn_s   = press_r[B_DOWN] & ~press_r[B_UP] & ~press_r[B_SEL] & ~press_r[B_MENU];
   end

   // Auto-repeat frame counting while up/down is held in EDIT; a menu/sel press restarts it
   always_comb begin
      held_up_s      = deb_r[B_UP];
      held_dn_s      = deb_r[B_DOWN] & ~deb_r[B_UP];
      rpt_run_s      = (state_r == ST_EDIT) & (held_up_s | held_dn_s) & ~ev_menu_s & ~ev_sel_s;
      rpt_fire_s     = 1'b0;
      rpt_delay_nx_s = rpt_delay_r;
      rpt_rate_nx_s  = rpt_rate_r;
      if (!rpt_run_s) begin
         rpt_delay_nx_s = '0;
         rpt_rate_nx_s  = '0;
      end else if (newframe) begin
         if (rpt_delay_r < RD_W'(RPT_DELAY)) begin
            rpt_delay_nx_s = rpt_delay_r + RD_W'(1);
            if (rpt_delay_r == RD_W'(RPT_DELAY - 1)) begin
               rpt_fire_s = 1'b1;
            end else begin
               rpt_fire_s = 1'b0;
            end
         end else begin
            if (rpt_rate_r == RR_W'(RPT_RATE - 1)) begin
               rpt_rate_nx_s = '0;
               rpt_fire_s    = 1'b1;
            end else begin
               rpt_rate_nx_s = rpt_rate_r + RR_W'(1);
            end
         end
      end else begin
         rpt_delay_nx_s = rpt_delay_r;
         rpt_rate_nx_s  = rpt_rate_r;
      end
      do_inc_s = ev_up_s | (rpt_fire_s & held_up_s);
      do_dec_s = ~do_inc_s & (ev_dn_s | (rpt_fire_s & held_dn_s));
   end

   // Auto-repeat counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rpt_delay_r <= '0;
         rpt_rate_r  <= '0;
      end else begin
         rpt_delay_r <= rpt_delay_nx_s;
         rpt_rate_r  <= rpt_rate_nx_s;
      end
   end

   // Navigate/edit state machine with registered status, cursor and pending values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         menu_on_r     <= 1'b0;
         edit_active_r <= 1'b0;
         cursor_r      <= 2'd0;
         for (int i = 0; i < 4; i++) begin
            pend_r[i] <= 20'h00000;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ev_menu_s) begin
                  state_r       <= ST_NAV;
                  menu_on_r     <= 1'b1;
                  edit_active_r <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_NAV: begin
               if (ev_menu_s) begin
                  state_r       <= ST_IDLE;
                  menu_on_r     <= 1'b0;
                  edit_active_r <= 1'b0;
               end else if (ev_sel_s) begin
                  state_r       <= ST_EDIT;
                  edit_active_r <= 1'b1;
               end else if (ev_up_s) begin
                  cursor_r <= cursor_r - 2'd1;
               end else if (ev_dn_s) begin
                  cursor_r <= cursor_r + 2'd1;
               end else begin
                  state_r <= ST_NAV;
               end
            end
            ST_EDIT: begin
               if (ev_menu_s) begin
                  state_r       <= ST_IDLE;
                  menu_on_r     <= 1'b0;
                  edit_active_r <= 1'b0;
               end else if (ev_sel_s) begin
                  state_r       <= ST_NAV;
                  edit_active_r <= 1'b0;
               end else if (do_inc_s) begin
                  pend_r[cursor_r] <= bcd_inc(pend_r[cursor_r], param_max(cursor_r));
               end else if (do_dec_s) begin
                  pend_r[cursor_r] <= bcd_dec(pend_r[cursor_r], param_max(cursor_r));
               end else begin
                  state_r <= ST_EDIT;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               menu_on_r     <= 1'b0;
               edit_active_r <= 1'b0;
            end
         endcase
      end
   end

   // Frame-synchronous snapshot of all four pending values
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_mode_r <= '0;
         out_agc_r  <= '0;
         out_lvl1_r <= '0;
         out_lvl2_r <= '0;
      end else if (newframe) begin
         out_mode_r <= bit_data_in'(pend_r[0]);
         out_agc_r  <= bit_data_in'(pend_r[1]);
         out_lvl1_r <= bit_data_in'(pend_r[2]);
         out_lvl2_r <= bit_data_in'(pend_r[3]);
      end else begin
         out_mode_r <= out_mode_r;
         out_agc_r  <= out_agc_r;
         out_lvl1_r <= out_lvl1_r;
         out_lvl2_r <= out_lvl2_r;
      end
   end

   assign menu_on      = menu_on_r;
   assign edit_active  = edit_active_r;
   assign cursor       = cursor_r;
   assign out_mode     = out_mode_r;
   assign out_Type_AGC = out_agc_r;
   assign out_Set_LVL1 = out_lvl1_r;
   assign out_Set_LVL2 = out_lvl2_r;

endmodule

// File: tb/tb_menu_param_ctrl.sv
// Self-checking bench for menu_param_ctrl: table of button steps with a
// snapshot scoreboard, plus hand sequences for latency, glitches,
// auto-repeat, simultaneous presses and asynchronous reset.
module tb_menu_param_ctrl;

   localparam int DEB = 16;
   localparam int BM  = 0;
   localparam int BS  = 1;
   localparam int BU  = 2;
   localparam int BD  = 3;

   logic        clk = 1'b0;
   logic        rst, newframe, btn_up, btn_down, btn_sel, btn_menu;
   logic        menu_on, edit_active;
   logic [1:0]  cursor;
   logic [19:0] out_mode, out_Type_AGC, out_Set_LVL1, out_Set_LVL2;

   menu_param_ctrl dut (
      .clk(clk), .rst(rst), .newframe(newframe),
      .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel), .btn_menu(btn_menu),
      .menu_on(menu_on), .edit_active(edit_active), .cursor(cursor),
      .out_mode(out_mode), .out_Type_AGC(out_Type_AGC),
      .out_Set_LVL1(out_Set_LVL1), .out_Set_LVL2(out_Set_LVL2)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          btn;
      logic [1:0]  cur;
      logic        mon;
      logic        edt;
      logic [19:0] mode, agc, l1, l2;
   } vec_t;

   typedef struct {
      logic        mon;
      logic        edt;
      logic [1:0]  cur;
      logic [19:0] mode, agc, l1, l2;
   } snap_t;

   vec_t  tbl[$];
   snap_t sb[$];
   snap_t shown;
   int    checks   = 0;
   int    failures = 0;

   function automatic vec_t mk(input int b, input logic [1:0] c, input logic mo, input logic ed,
                               input logic [19:0] m, input logic [19:0] a,
                               input logic [19:0] l1, input logic [19:0] l2);
      vec_t v;
      v.btn = b; v.cur = c; v.mon = mo; v.edt = ed;
      v.mode = m; v.agc = a; v.l1 = l1; v.l2 = l2;
      return v;
   endfunction

   function automatic snap_t mksnap(input logic mo, input logic ed, input logic [1:0] c,
                                    input logic [19:0] m, input logic [19:0] a,
                                    input logic [19:0] l1, input logic [19:0] l2);
      snap_t s;
      s.mon = mo; s.edt = ed; s.cur = c;
      s.mode = m; s.agc = a; s.l1 = l1; s.l2 = l2;
      return s;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_btn(input int b, input logic v);
      case (b)
         BM:      btn_menu = v;
         BS:      btn_sel  = v;
         BU:      btn_up   = v;
         default: btn_down = v;
      endcase
   endtask

   task automatic press(input int b);
      set_btn(b, 1'b1);
      tick(DEB + 6);
      set_btn(b, 1'b0);
      tick(DEB + 6);
   endtask

   task automatic frame();
      newframe = 1'b1;
      tick(1);
      newframe = 1'b0;
      tick(3);
   endtask

   task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, got, exp);
      end
   endtask

   task automatic compare(input string tag);
      snap_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard empty actual=0 required=1", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, " menu_on"},     20'(menu_on),     20'(e.mon));
         chk({tag, " edit_active"}, 20'(edit_active), 20'(e.edt));
         chk({tag, " cursor"},      20'(cursor),      20'(e.cur));
         chk({tag, " out_mode"},    out_mode,         e.mode);
         chk({tag, " out_AGC"},     out_Type_AGC,     e.agc);
         chk({tag, " out_LVL1"},    out_Set_LVL1,     e.l1);
         chk({tag, " out_LVL2"},    out_Set_LVL2,     e.l2);
      end
   endtask

   // One table step: press, check status with the old frame values, then a frame
   task automatic do_step(input vec_t v, input string tag);
      press(v.btn);
      sb.push_back(mksnap(v.mon, v.edt, v.cur, shown.mode, shown.agc, shown.l1, shown.l2));
      compare({tag, " pre"});
      frame();
      shown = mksnap(v.mon, v.edt, v.cur, v.mode, v.agc, v.l1, v.l2);
      sb.push_back(shown);
      compare({tag, " post"});
   endtask

   initial begin
      // Step table: starts in NAV, cursor 0, all parameters zero
      tbl.push_back(mk(BU, 2'd3, 1'b1, 1'b0, 20'h0,  20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BU, 2'd2, 1'b1, 1'b0, 20'h0,  20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BS, 2'd2, 1'b1, 1'b1, 20'h0,  20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd2, 1'b1, 1'b1, 20'h0,  20'h0, 20'h99999, 20'h0));
      tbl.push_back(mk(BU, 2'd2, 1'b1, 1'b1, 20'h0,  20'h0, 20'h00000, 20'h0));
      tbl.push_back(mk(BS, 2'd2, 1'b1, 1'b0, 20'h0,  20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd3, 1'b1, 1'b0, 20'h0,  20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd0, 1'b1, 1'b0, 20'h0,  20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BS, 2'd0, 1'b1, 1'b1, 20'h0,  20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd0, 1'b1, 1'b1, 20'h15, 20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BU, 2'd0, 1'b1, 1'b1, 20'h00, 20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd0, 1'b1, 1'b1, 20'h15, 20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BS, 2'd0, 1'b1, 1'b0, 20'h15, 20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd1, 1'b1, 1'b0, 20'h15, 20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BS, 2'd1, 1'b1, 1'b1, 20'h15, 20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd1, 1'b1, 1'b1, 20'h15, 20'h3, 20'h0,     20'h0));
      tbl.push_back(mk(BU, 2'd1, 1'b1, 1'b1, 20'h15, 20'h0, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd1, 1'b1, 1'b1, 20'h15, 20'h3, 20'h0,     20'h0));
      tbl.push_back(mk(BM, 2'd1, 1'b0, 1'b0, 20'h15, 20'h3, 20'h0,     20'h0));
      tbl.push_back(mk(BU, 2'd1, 1'b0, 1'b0, 20'h15, 20'h3, 20'h0,     20'h0));
      tbl.push_back(mk(BM, 2'd1, 1'b1, 1'b0, 20'h15, 20'h3, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd2, 1'b1, 1'b0, 20'h15, 20'h3, 20'h0,     20'h0));
      tbl.push_back(mk(BD, 2'd3, 1'b1, 1'b0, 20'h15, 20'h3, 20'h0,     20'h0));
      tbl.push_back(mk(BS, 2'd3, 1'b1, 1'b1, 20'h15, 20'h3, 20'h0,     20'h0));
      for (int k = 1; k <= 9; k++) begin
         tbl.push_back(mk(BU, 2'd3, 1'b1, 1'b1, 20'h15, 20'h3, 20'h0, 20'(k)));
      end

      rst = 1'b1; newframe = 1'b0;
      btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0; btn_menu = 1'b0;
      tick(3);
      sb.push_back(mksnap(1'b0, 1'b0, 2'd0, 20'h0, 20'h0, 20'h0, 20'h0));
      compare("reset");
      rst = 1'b0;
      tick(2);

      // Menu press latency: visible exactly 3+DEB edges after the raw edge
      btn_menu = 1'b1;
      tick(2 + DEB);
      chk("menu_early", 20'(menu_on), 20'h0);
      tick(1);
      chk("menu_latency", 20'(menu_on), 20'h1);
      tick(2 * DEB - 3);
      btn_menu = 1'b0;
      tick(DEB + 6);
      shown = mksnap(1'b1, 1'b0, 2'd0, 20'h0, 20'h0, 20'h0, 20'h0);
      sb.push_back(shown);
      compare("menu_held_once");

      // Short glitches on up must not move the cursor
      for (int g = 0; g < 3; g++) begin
         btn_up = 1'b1;
         tick(5);
         btn_up = 1'b0;
         tick(10);
      end
      sb.push_back(shown);
      compare("glitch");

      for (int i = 0; i < tbl.size(); i++) begin
         do_step(tbl[i], $sformatf("step%0d", i));
      end

      // Auto-repeat on LVL2 starting from 0009
      btn_up = 1'b1;
      tick(DEB + 6);
      sb.push_back(shown);
      compare("hold_press");
      for (int f = 1; f <= 40; f++) begin
         frame();
         if (f == 29 || f == 30) begin
            sb.push_back(mksnap(1'b1, 1'b1, 2'd3, 20'h15, 20'h3, 20'h0, 20'h00010));
            compare($sformatf("hold_f%0d", f));
         end else if (f == 31) begin
            sb.push_back(mksnap(1'b1, 1'b1, 2'd3, 20'h15, 20'h3, 20'h0, 20'h00011));
            compare("hold_f31");
         end
      end
      btn_up = 1'b0;
      tick(DEB + 6);
      frame();
      shown.l2 = 20'h00013;
      sb.push_back(shown);
      compare("hold_end");

      do_step(mk(BS, 2'd3, 1'b1, 1'b0, 20'h15, 20'h3, 20'h0, 20'h00013), "sel_nav");

      // sel and up debounced together in NAV: sel wins, cursor stays
      btn_sel = 1'b1; btn_up = 1'b1;
      tick(DEB + 6);
      btn_sel = 1'b0; btn_up = 1'b0;
      tick(DEB + 6);
      shown.edt = 1'b1;
      sb.push_back(shown);
      compare("sel_up_same");
      frame();
      sb.push_back(shown);
      compare("sel_up_frame");

      // Asynchronous reset mid-edit, with menu held mid-debounce
      btn_menu = 1'b1;
      tick(8);
      #2 rst = 1'b1;
      #1;
      sb.push_back(mksnap(1'b0, 1'b0, 2'd0, 20'h0, 20'h0, 20'h0, 20'h0));
      compare("async_reset");
      tick(2);
      rst = 1'b0;
      tick(2 + DEB);
      chk("post_reset_early", 20'(menu_on), 20'h0);
      tick(1);
      chk("post_reset_menu", 20'(menu_on), 20'h1);
      chk("post_reset_cursor", 20'(cursor), 20'h0);
      btn_menu = 1'b0;
      tick(DEB + 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
